mux_8to1: RTL and testbench

MUX_8TO1 -- requirements
Module: mux_8to1

---
 rtl/mux_8to1_pkg.sv | 14 +
 rtl/mux_8to1_core.sv | 28 ++
 rtl/mux_8to1.sv | 69 ++++++
 tb/tb_mux_8to1.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_8to1_pkg.sv
// ----------------------------------------------------------------------------
// mux_8to1_pkg : shared constants and select type for the 8:1 multiplexer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_8to1_pkg;
    localparam int N_INPUTS = 8;
    localparam int SEL_W    = 3;

    typedef logic [SEL_W-1:0] sel_t;
endpackage : mux_8to1_pkg

`default_nettype wire

// File: rtl/mux_8to1_core.sv
// ----------------------------------------------------------------------------
// mux_8to1_core : purely combinational 8:1 selector over a packed input bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_8to1_core
    import mux_8to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [N_INPUTS*WIDTH-1:0] I,
    input  sel_t                      S,
    output logic [WIDTH-1:0]          Y
);

    logic [WIDTH-1:0] w_in [N_INPUTS];

    // Array form keeps an unknown select propagating as X in simulation.
    for (genvar k = 0; k < N_INPUTS; k++) begin : g_unpack
        assign w_in[k] = I[k*WIDTH +: WIDTH];
    end

    assign Y = w_in[S];

endmodule : mux_8to1_core

`default_nettype wire

// File: rtl/mux_8to1.sv
// ----------------------------------------------------------------------------
// mux_8to1 : 8:1 multiplexer with optional registered output stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS*WIDTH-1:0] I,
    input  sel_t                      S,
    input  logic                      in_valid,
    output logic [WIDTH-1:0]          Y,
    output logic [WIDTH-1:0]          Y_q,
    output logic                      out_valid,
    output sel_t                      S_q
);

    logic [WIDTH-1:0] w_y;

    mux_8to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .I (I),
        .S (S),
        .Y (w_y)
    );

    assign Y = w_y;

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] r_yq;
        sel_t             r_sq;
        logic             r_valid;

        // Reset wins over a simultaneous valid beat; idle beats hold data.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_yq    <= '0;
                r_sq    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_yq <= w_y;
                    r_sq <= S;
                end
            end
        end

        assign Y_q       = r_yq;
        assign S_q       = r_sq;
        assign out_valid = r_valid;
    end else begin : g_no_reg
        logic w_unused;
        assign w_unused  = &{1'b0, clk, rst_n, in_valid};
        assign Y_q       = '0;
        assign S_q       = '0;
        assign out_valid = 1'b0;
    end

endmodule : mux_8to1

`default_nettype wire

// File: tb/tb_mux_8to1.sv
// ----------------------------------------------------------------------------
// tb_mux_8to1 : directed + random self-checking bench for mux_8to1 (WIDTH 1 and 4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mux_8to1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i1;
    logic [31:0] i4;
    logic [2:0]  s;
    logic        in_valid;

    logic        y1, yq1, ov1;
    logic [2:0]  sq1;
    logic [3:0]  y4, yq4;
    logic        ov4;
    logic [2:0]  sq4;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference state for the registered outputs
    logic [0:0] m_yq1;
    logic [3:0] m_yq4;
    logic [2:0] m_sq;
    logic       m_ov;

    mux_8to1 #(.WIDTH(1), .OUT_REG(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (i1),
        .S         (s),
        .in_valid  (in_valid),
        .Y         (y1),
        .Y_q       (yq1),
        .out_valid (ov1),
        .S_q       (sq1)
    );

    mux_8to1 #(.WIDTH(4), .OUT_REG(1)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (i4),
        .S         (s),
        .in_valid  (in_valid),
        .Y         (y4),
        .Y_q       (yq4),
        .out_valid (ov4),
        .S_q       (sq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:0] sel1(input logic [7:0] d, input logic [2:0] k);
        return 1'((d >> k) & 8'h1);
    endfunction

    function automatic logic [3:0] sel4(input logic [31:0] d, input logic [2:0] k);
        return 4'((d >> (32'(k) * 4)) & 32'hF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_yq1 <= '0;
            m_yq4 <= '0;
            m_sq  <= '0;
            m_ov  <= 1'b0;
        end else begin
            m_ov <= in_valid;
            if (in_valid) begin
                m_yq1 <= sel1(i1, s);
                m_yq4 <= sel4(i4, s);
                m_sq  <= s;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_y1",   32'(y1),  32'(sel1(i1, s)));
            check("model_y4",   32'(y4),  32'(sel4(i4, s)));
            check("model_yq1",  32'(yq1), 32'(m_yq1));
            check("model_yq4",  32'(yq4), 32'(m_yq4));
            check("model_sq1",  32'(sq1), 32'(m_sq));
            check("model_sq4",  32'(sq4), 32'(m_sq));
            check("model_ov1",  32'(ov1), 32'(m_ov));
            check("model_ov4",  32'(ov4), 32'(m_ov));
        end
    end

    // Drive just after a falling edge, return on the next falling edge.
    task automatic step(input logic [7:0] a1, input logic [31:0] a4, input logic [2:0] k,
                        input logic v, input logic r);
        #1;
        i1       = a1;
        i4       = a4;
        s        = k;
        in_valid = v;
        rst_n    = r;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_aa [8];
        exp_aa = '{0, 1, 0, 1, 0, 1, 0, 1};

        rst_n = 1'b0; in_valid = 1'b1; i1 = 8'hFF; i4 = 32'hFFFF_FFFF; s = 3'b111;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset held with a valid beat present
        for (int n = 0; n < 2; n++) begin
            step(8'hFF, 32'hFFFF_FFFF, 3'b111, 1'b1, 1'b0);
            check("rst_yq",  32'(yq1), 32'h0);
            check("rst_sq",  32'(sq1), 32'h0);
            check("rst_ov",  32'(ov1), 32'h0);
            check("rst_y",   32'(y1),  32'h1);
        end

        // Single capture then hold
        step(8'b1010_1010, 32'h0, 3'b011, 1'b1, 1'b1);
        check("cap_yq", 32'(yq1), 32'h1);
        check("cap_sq", 32'(sq1), 32'h3);
        check("cap_ov", 32'(ov1), 32'h1);
        step(8'b1010_1010, 32'h0, 3'b000, 1'b0, 1'b1);
        check("hold_yq", 32'(yq1), 32'h1);
        check("hold_sq", 32'(sq1), 32'h3);
        check("hold_ov", 32'(ov1), 32'h0);
        check("hold_y",  32'(y1),  32'h0);

        for (int k = 0; k < 8; k++) begin
            step(8'b1010_1010, 32'h0, 3'(k), 1'b0, 1'b1);
            check("sweep_aa", 32'(y1), 32'(exp_aa[k]));
        end
        for (int k = 0; k < 8; k++) begin
            step(8'b0101_0101, 32'h0, 3'(k), 1'b0, 1'b1);
            check("sweep_55", 32'(y1), 32'(1 - exp_aa[k]));
        end
        for (int k = 0; k < 8; k++) begin
            step(8'b0001_0000, 32'h0, 3'(k), 1'b0, 1'b1);
            check("onehot", 32'(y1), (k == 4) ? 32'h1 : 32'h0);
        end

        // Nibble sweep: each captured beat visible on Y_q at the next sample
        for (int k = 0; k < 8; k++) begin
            step(8'h0, 32'h7654_3210, 3'(k), 1'b1, 1'b1);
            check("w4_y",  32'(y4),  32'(k));
            check("w4_yq", 32'(yq4), 32'(k));
            check("w4_sq", 32'(sq4), 32'(k));
        end

        // Mid-stream reset discards the pending beat
        step(8'hFF, 32'hAAAA_AAAA, 3'b101, 1'b1, 1'b0);
        check("mid_rst_yq4", 32'(yq4), 32'h0);
        check("mid_rst_ov",  32'(ov4), 32'h0);
        step(8'hFF, 32'h00F0_0000, 3'b101, 1'b1, 1'b1);
        check("post_rst_yq4", 32'(yq4), 32'hF);
        check("post_rst_sq4", 32'(sq4), 32'h5);

        for (int n = 0; n < 1000; n++) begin
            step(8'($urandom), 32'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_8to1

`default_nettype wire
